// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
// Shared definitions for the instruction encoder/loader and the opcode control
// decoder: mnemonic indices, 6-bit op codes, R/I/J field bit positions, loader
// FSM state encodings, a field bundle type and a mnemonic -> format helper.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

    // Mnemonic indices as presented on in_mnem; 13..15 are illegal.
    localparam logic [3:0] MN_ADD  = 4'd0;
    localparam logic [3:0] MN_SUB  = 4'd1;
    localparam logic [3:0] MN_AND  = 4'd2;
    localparam logic [3:0] MN_OR   = 4'd3;
    localparam logic [3:0] MN_SLT  = 4'd4;
    localparam logic [3:0] MN_SW   = 4'd5;
    localparam logic [3:0] MN_LW   = 4'd6;
    localparam logic [3:0] MN_ADDI = 4'd7;
    localparam logic [3:0] MN_ANDI = 4'd8;
    localparam logic [3:0] MN_ORI  = 4'd9;
    localparam logic [3:0] MN_SLTI = 4'd10;
    localparam logic [3:0] MN_BEQ  = 4'd11;
    localparam logic [3:0] MN_J    = 4'd12;

    // Op codes, identical to the map used by the control decoder.
    localparam logic [5:0] OP_ADD  = 6'b001111;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b000001;
    localparam logic [5:0] OP_SLT  = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Instruction word field positions.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Loader FSM state encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } instr_fmt_e;

    typedef struct packed {
        logic [3:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    // Instruction format implied by a mnemonic index.
    function automatic instr_fmt_e mnem_format(input logic [3:0] mnem);
        instr_fmt_e fmt;
        case (mnem)
            MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT:            fmt = FMT_R;
            MN_SW, MN_LW, MN_ADDI, MN_ANDI, MN_ORI, MN_SLTI,
            MN_BEQ:                                          fmt = FMT_I;
            MN_J:                                            fmt = FMT_J;
            default:                                         fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_word_encoder.sv
// -----------------------------------------------------------------------------
// instr_word_encoder
// Purely combinational: packs symbolic instruction fields into a 32-bit word
// and flags mnemonics that have no encoding.
// Ports:
//   mnem    in  4   mnemonic index
//   rs/rt/rd in 5   register fields
//   imm     in  16  I-type immediate / offset
//   target  in  26  J-type target
//   word    out 32  encoded instruction (0 when illegal)
//   illegal out 1   mnemonic has no encoding
// -----------------------------------------------------------------------------
module instr_word_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] op_s;
    instr_fmt_e fmt_s;

    // Op-code lookup from mnemonic
    always_comb begin
        op_s = 6'b000000;
        case (mnem)
            MN_ADD:  op_s = OP_ADD;
            MN_SUB:  op_s = OP_SUB;
            MN_AND:  op_s = OP_AND;
            MN_OR:   op_s = OP_OR;
            MN_SLT:  op_s = OP_SLT;
            MN_SW:   op_s = OP_SW;
            MN_LW:   op_s = OP_LW;
            MN_ADDI: op_s = OP_ADDI;
            MN_ANDI: op_s = OP_ANDI;
            MN_ORI:  op_s = OP_ORI;
            MN_SLTI: op_s = OP_SLTI;
            MN_BEQ:  op_s = OP_BEQ;
            MN_J:    op_s = OP_J;
            default: op_s = 6'b000000;
        endcase
    end

    // Field packing according to the instruction format
    always_comb begin
        fmt_s   = mnem_format(mnem);
        word    = 32'h0000_0000;
        illegal = 1'b0;
        word[OP_MSB:OP_LSB] = op_s;
        case (fmt_s)
            FMT_R: begin
                // Shamt/funct bits [10:0] stay zero.
                word[RS_MSB:RS_LSB] = rs;
                word[RT_MSB:RT_LSB] = rt;
                word[RD_MSB:RD_LSB] = rd;
            end
            FMT_I: begin
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            FMT_J: begin
                word[TGT_MSB:TGT_LSB] = target;
            end
            default: begin
                word    = 32'h0000_0000;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts symbolic instruction fields over valid/ready, encodes each into a
// 32-bit word and writes the words to consecutive instruction-memory addresses
// through a we/ready handshake. Flags illegal mnemonics and overflow.
// Optional build macro: PROG_CHECKSUM_EN adds output checksum[31:0], the XOR
// of all completed writes since the last rst/start.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               clear pointer/flags and begin loading
//   in_valid/in_ready   field handshake; in_ready only in LOAD
//   in_mnem, in_rs, in_rt, in_rd, in_imm, in_target, in_last  fields
//   mem_we/mem_ready    write handshake; mem_addr/mem_wdata held while pending
//   done, err           sticky status until start/rst
//   count               number of completed writes
//   checksum            (PROG_CHECKSUM_EN only) XOR of written words
// -----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              in_ready_r;
    logic              mem_we_r;
    logic              done_r;
    logic              err_r;
    logic              last_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [ADDR_W:0]   count_r;

    instr_fields_t     fields_s;
    logic [31:0]       enc_word_s;
    logic              enc_illegal_s;
    logic              accept_s;
    logic              full_s;
    logic              reject_s;
    logic              wr_done_s;

    // Bundle the incoming fields for the encoder
    always_comb begin
        fields_s        = '0;
        fields_s.mnem   = in_mnem;
        fields_s.rs     = in_rs;
        fields_s.rt     = in_rt;
        fields_s.rd     = in_rd;
        fields_s.imm    = in_imm;
        fields_s.target = in_target;
    end

    instr_word_encoder u_encoder (
        .mnem    (fields_s.mnem),
        .rs      (fields_s.rs),
        .rt      (fields_s.rt),
        .rd      (fields_s.rd),
        .imm     (fields_s.imm),
        .target  (fields_s.target),
        .word    (enc_word_s),
        .illegal (enc_illegal_s)
    );

    // Handshake decode and next-state selection
    always_comb begin
        // in_ready_r is high exactly while in LOAD; mem_we_r exactly in WRITE.
        accept_s    = in_valid & in_ready_r;
        // Memory already holds 2**ADDR_W words: another write would wrap
        // over BASE_ADDR, so the accept is rejected instead.
        full_s      = (count_r == DEPTH_C);
        reject_s    = accept_s & (enc_illegal_s | full_s);
        wr_done_s   = mem_we_r & mem_ready;
        state_nxt_s = state_r;
        if (start) begin
            // start wins over everything but rst, including a pending write
            // and a simultaneous in_valid.
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_LOAD: begin
                    if (reject_s) begin
                        state_nxt_s = ST_ERR;
                    end else if (accept_s) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (wr_done_s) begin
                        state_nxt_s = last_r ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                ST_ERR:  state_nxt_s = ST_ERR;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, handshake outputs, write pointer and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_C;
            mem_wdata_r <= 32'h0000_0000;
            last_r      <= 1'b0;
            count_r     <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_LOAD);
            mem_we_r   <= (state_nxt_s == ST_WRITE);
            if (start) begin
                mem_addr_r <= BASE_C;
                count_r    <= '0;
                done_r     <= 1'b0;
                err_r      <= 1'b0;
                last_r     <= 1'b0;
            end else begin
                if (accept_s && !reject_s) begin
                    mem_wdata_r <= enc_word_s;
                    last_r      <= in_last;
                end
                if (wr_done_s) begin
                    mem_addr_r <= mem_addr_r + ADDR_W'(1);
                    count_r    <= count_r + (ADDR_W + 1)'(1);
                end
                if (state_nxt_s == ST_DONE) begin
                    done_r <= 1'b1;
                end
                if (state_nxt_s == ST_ERR) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Running XOR of every completed write
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= 32'h0000_0000;
        end else if (start) begin
            checksum_r <= 32'h0000_0000;
        end else if (wr_done_s) begin
            checksum_r <= checksum_r ^ mem_wdata_r;
        end
    end

    assign checksum = checksum_r;
`endif

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign err       = err_r;
    assign count     = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader (ADDR_W=2 so overflow is reachable).
// A transaction-level model predicts every memory write, count, done, err and
// checksum; one negedge process compares the DUT against it every cycle, and
// the directed sequence pins the model with hand-computed words.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;
`ifdef PROG_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mnem   (in_mnem),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err),
        .count     (count)
`ifdef PROG_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         wr_log[$];
    int          m_accepted;
    int          m_written;
    bit          m_done;
    bit          m_err;
    logic [31:0] m_xor;

    // Op codes indexed by mnemonic, ADD..J.
    int op_tab [13] = '{15, 6, 0, 1, 7, 43, 35, 8, 12, 13, 10, 4, 2};

    function automatic logic [31:0] m_enc(input int mn, input int rs, input int rt,
                                          input int rd, input int imm, input int tg);
        logic [31:0] w;
        w = 32'(op_tab[mn]) << 26;
        if (mn <= 4)       w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        else if (mn <= 11) w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        else               w = w | 32'(tg);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: tracks accepts and completed writes at each rising edge
    always @(posedge clk) begin
        if (rst || start) begin
            exp_q.delete();
            m_accepted = 0;
            m_written  = 0;
            m_done     = 1'b0;
            m_err      = 1'b0;
            m_xor      = 32'h0;
        end else begin
            if (mem_we && mem_ready) begin
                wr_log.push_back('{int'(mem_addr), mem_wdata, 1'b0});
                if (exp_q.size() > 0) begin
                    m_xor = m_xor ^ exp_q[0].data;
                    if (exp_q[0].last) m_done = 1'b1;
                    void'(exp_q.pop_front());
                    m_written++;
                end
            end
            if (in_valid && in_ready) begin
                if (int'(in_mnem) > 12 || m_accepted >= DEPTH) begin
                    m_err = 1'b1;
                end else begin
                    exp_q.push_back('{(BASE + m_accepted) % DEPTH,
                                      m_enc(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                                            int'(in_imm), int'(in_target)),
                                      in_last});
                    m_accepted++;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("count", 32'(count), 32'(m_written));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
`ifdef PROG_CHECKSUM_EN
            check("checksum", checksum, m_xor);
`endif
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_we), 32'd0);
                end else begin
                    check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    check("mem_wdata", mem_wdata, exp_q[0].data);
                    check("in_ready_in_write", 32'(in_ready), 32'd0);
                end
            end
            if (done || err) begin
                check("in_ready_when_halted", 32'(in_ready), 32'd0);
                check("mem_we_when_halted", 32'(mem_we), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg,
                        input logic last);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd;
            in_imm = imm; in_target = tg; in_last = last;
            in_valid = 1'b1;
            step(1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (wr_log.size() < n && k < 100) begin
            step(1);
            k++;
        end
        if (wr_log.size() < n) check("write_timeout", 32'(wr_log.size()), 32'(n));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        in_mnem = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_imm = 16'd0; in_target = 26'd0; in_last = 1'b0;
        step(3);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // R-type ADD rs=1 rt=2 rd=3
        pulse_start(); wr_log.delete();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        wait_writes(1);
        if (wr_log.size() >= 1) begin
            check("add_word", wr_log[0].data, 32'h3C221800);
            check("add_addr", 32'(wr_log[0].addr), 32'd0);
        end
        check("add_count", 32'(count), 32'd1);

        // ADD then LW (last): checksum and done
        pulse_start(); wr_log.delete();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        send(4'd6, 5'd0, 5'd4, 5'd0, 16'h0008, 26'h0, 1'b1);
        wait_writes(2);
        step(1);
        check("cks_done", 32'(done), 32'd1);
`ifdef PROG_CHECKSUM_EN
        check("cks_value", checksum, 32'hB0261808);
`endif

        // LW then J (last)
        pulse_start(); wr_log.delete();
        send(4'd6, 5'd0, 5'd4, 5'd0, 16'h0008, 26'h0, 1'b0);
        send(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        wait_writes(2);
        step(1);
        if (wr_log.size() >= 2) begin
            check("lw_word", wr_log[0].data, 32'h8C040008);
            check("lw_addr", 32'(wr_log[0].addr), 32'd0);
            check("j_word", wr_log[1].data, 32'h08000010);
            check("j_addr", 32'(wr_log[1].addr), 32'd1);
        end
        check("ij_done", 32'(done), 32'd1);
        check("ij_count", 32'(count), 32'd2);

        // Backpressure: SLT held for 3 cycles, then ADDI (last)
        pulse_start(); wr_log.delete();
        mem_ready = 1'b0;
        send(4'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_mem_we", 32'(mem_we), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_addr", 32'(mem_addr), 32'd0);
            check("bp_wdata", mem_wdata, 32'h1CA63800);
            step(1);
        end
        mem_ready = 1'b1;
        send(4'd7, 5'd2, 5'd3, 5'd0, 16'hFFFF, 26'h0, 1'b1);
        wait_writes(2);
        step(1);
        if (wr_log.size() >= 2) check("addi_word", wr_log[1].data, 32'h2043FFFF);
        check("bp_done", 32'(done), 32'd1);

        // Illegal mnemonic 4'hE
        pulse_start(); wr_log.delete();
        send(4'hE, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("ill_err", 32'(err), 32'd1);
            check("ill_mem_we", 32'(mem_we), 32'd0);
            check("ill_in_ready", 32'(in_ready), 32'd0);
            step(1);
        end
        check("ill_no_write", 32'(wr_log.size()), 32'd0);
        pulse_start();
        check("ill_cleared", 32'(err), 32'd0);
        check("ill_restart_ready", 32'(in_ready), 32'd1);
        // Illegal 4'hD flagged last: error, never done
        send(4'hD, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        step(2);
        check("ill_last_err", 32'(err), 32'd1);
        check("ill_last_done", 32'(done), 32'd0);

        // Overflow: four writes fill the memory, fifth accept errors
        pulse_start(); wr_log.delete();
        send(4'd1, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b0);
        send(4'd5, 5'd29, 5'd31, 5'd0, 16'h0010, 26'h0, 1'b0);
        send(4'd9, 5'd1, 5'd1, 5'd0, 16'hABCD, 26'h0, 1'b0);
        send(4'd11, 5'd3, 5'd4, 5'd0, 16'hFFFE, 26'h0, 1'b0);
        wait_writes(4);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'h0001, 26'h0, 1'b0);
        step(3);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_writes", 32'(wr_log.size()), 32'd4);
        check("ovf_count", 32'(count), 32'd4);
        if (wr_log.size() >= 4) begin
            check("sub_word", wr_log[0].data, 32'h19095000);
            check("ovf_last_addr", 32'(wr_log[3].addr), 32'd3);
        end

        // start while a write is pending
        pulse_start(); wr_log.delete();
        send(4'd2, 5'd11, 5'd12, 5'd13, 16'h0, 26'h0, 1'b0);
        wait_writes(1);
        mem_ready = 1'b0;
        send(4'd8, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0, 1'b0);
        check("abort_pending_we", 32'(mem_we), 32'd1);
        check("abort_pending_addr", 32'(mem_addr), 32'd1);
        pulse_start();
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        mem_ready = 1'b1;

        // start and in_valid together: fields ignored
        wr_log.delete();
        in_mnem = 4'd3; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_last = 1'b1;
        start = 1'b1; in_valid = 1'b1;
        step(1);
        start = 1'b0; in_valid = 1'b0;
        step(4);
        check("sv_no_write", 32'(wr_log.size()), 32'd0);
        check("sv_count", 32'(count), 32'd0);
        check("sv_in_ready", 32'(in_ready), 32'd1);
        send(4'd10, 5'd4, 5'd5, 5'd0, 16'h8000, 26'h0, 1'b0);
        send(4'd3, 5'd17, 5'd18, 5'd19, 16'h0, 26'h0, 1'b1);
        wait_writes(2);
        step(1);
        check("sv_done", 32'(done), 32'd1);
        check("sv_addr_after", 32'(mem_addr), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
